// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and a saturating hazard-bubble counter.
// Optional feature macro: LOAD_USE_DETECT_EN (undefined: no detection, no counter flops).
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic            clk_i,
  input  logic            rst_n,
  input  logic            ID_valid_i,
  input  logic [4:0]      ID_Rs1_i,
  input  logic [4:0]      ID_Rs2_i,
  input  logic [4:0]      ID_Rd_i,
  input  logic [XLEN-1:0] ID_RS1data_i,
  input  logic [XLEN-1:0] ID_RS2data_i,
  input  logic [XLEN-1:0] ID_Imm_i,
  input  logic [XLEN-1:0] ID_PC_i,
  input  logic            ID_RegWrite_i,
  input  logic            ID_MemRead_i,
  input  logic            ID_MemWrite_i,
  input  logic            ID_MemtoReg_i,
  input  logic            ID_ALUSrc_i,
  input  logic            ID_Branch_i,
  input  logic [3:0]      ID_ALUOp_i,
  input  logic            flush_i,
  input  logic            stall_ext_i,
  output logic            ID_EX_valid_o,
  output logic [4:0]      ID_EX_Rs1_o,
  output logic [4:0]      ID_EX_Rs2_o,
  output logic [4:0]      ID_EX_Rd_o,
  output logic [XLEN-1:0] ID_EX_RS1data_o,
  output logic [XLEN-1:0] ID_EX_RS2data_o,
  output logic [XLEN-1:0] ID_EX_Imm_o,
  output logic [XLEN-1:0] ID_EX_PC_o,
  output logic            ID_EX_RegWrite_o,
  output logic            ID_EX_MemRead_o,
  output logic            ID_EX_MemWrite_o,
  output logic            ID_EX_MemtoReg_o,
  output logic            ID_EX_ALUSrc_o,
  output logic            ID_EX_Branch_o,
  output logic [3:0]      ID_EX_ALUOp_o,
  output logic            hazard_stall_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  logic hazard;
  logic bubble;

`ifdef LOAD_USE_DETECT_EN
  assign hazard = ID_EX_valid_o & ID_EX_MemRead_o & (ID_EX_Rd_o != 5'd0) & ID_valid_i &
                  ((ID_EX_Rd_o == ID_Rs1_i) | (ID_EX_Rd_o == ID_Rs2_i));

  // Only load-use bubbles are counted; flush takes priority and is not a hazard bubble.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n)
      bubble_cnt_o <= '0;
    else if (!stall_ext_i && !flush_i && hazard && (bubble_cnt_o != {CNT_W{1'b1}}))
      bubble_cnt_o <= bubble_cnt_o + 1'b1;
  end
`else
  assign hazard       = 1'b0;
  assign bubble_cnt_o = '0;
`endif

  assign hazard_stall_o = hazard & ~flush_i;
  assign bubble         = flush_i | hazard;

  // Bubbles zero valid, control and indices so forwarding never matches them;
  // data/PC/Imm deliberately hold to avoid needless toggling.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ID_EX_valid_o    <= 1'b0;
      ID_EX_Rs1_o      <= '0;
      ID_EX_Rs2_o      <= '0;
      ID_EX_Rd_o       <= '0;
      ID_EX_RS1data_o  <= '0;
      ID_EX_RS2data_o  <= '0;
      ID_EX_Imm_o      <= '0;
      ID_EX_PC_o       <= '0;
      ID_EX_RegWrite_o <= 1'b0;
      ID_EX_MemRead_o  <= 1'b0;
      ID_EX_MemWrite_o <= 1'b0;
      ID_EX_MemtoReg_o <= 1'b0;
      ID_EX_ALUSrc_o   <= 1'b0;
      ID_EX_Branch_o   <= 1'b0;
      ID_EX_ALUOp_o    <= '0;
    end else if (!stall_ext_i) begin
      if (bubble) begin
        ID_EX_valid_o    <= 1'b0;
        ID_EX_Rs1_o      <= '0;
        ID_EX_Rs2_o      <= '0;
        ID_EX_Rd_o       <= '0;
        ID_EX_RegWrite_o <= 1'b0;
        ID_EX_MemRead_o  <= 1'b0;
        ID_EX_MemWrite_o <= 1'b0;
        ID_EX_MemtoReg_o <= 1'b0;
        ID_EX_ALUSrc_o   <= 1'b0;
        ID_EX_Branch_o   <= 1'b0;
        ID_EX_ALUOp_o    <= '0;
      end else begin
        ID_EX_valid_o    <= ID_valid_i;
        ID_EX_Rs1_o      <= ID_valid_i ? ID_Rs1_i : 5'd0;
        ID_EX_Rs2_o      <= ID_valid_i ? ID_Rs2_i : 5'd0;
        ID_EX_Rd_o       <= ID_valid_i ? ID_Rd_i  : 5'd0;
        ID_EX_RS1data_o  <= ID_RS1data_i;
        ID_EX_RS2data_o  <= ID_RS2data_i;
        ID_EX_Imm_o      <= ID_Imm_i;
        ID_EX_PC_o       <= ID_PC_i;
        ID_EX_RegWrite_o <= ID_valid_i & ID_RegWrite_i;
        ID_EX_MemRead_o  <= ID_valid_i & ID_MemRead_i;
        ID_EX_MemWrite_o <= ID_valid_i & ID_MemWrite_i;
        ID_EX_MemtoReg_o <= ID_valid_i & ID_MemtoReg_i;
        ID_EX_ALUSrc_o   <= ID_valid_i & ID_ALUSrc_i;
        ID_EX_Branch_o   <= ID_valid_i & ID_Branch_i;
        ID_EX_ALUOp_o    <= ID_valid_i ? ID_ALUOp_i : 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: behavioural model checked every negedge plus hand-computed literals.
module tb_id_ex_stage;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;   // narrow counter so saturation is reachable quickly
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef LOAD_USE_DETECT_EN
  localparam int DET = 1;
`else
  localparam int DET = 0;
`endif
  // control vector order: {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch}
  localparam logic [5:0] C_LW  = 6'b110110;
  localparam logic [5:0] C_ADD = 6'b100000;
  localparam logic [5:0] C_SW  = 6'b001010;

  logic clk, rst_n;
  logic id_valid, flush, stall_ext;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [XLEN-1:0] id_d1, id_d2, id_imm, id_pc;
  logic [5:0] id_ctrl;
  logic [3:0] id_alu;

  logic ex_valid, ex_rw, ex_mr, ex_mw, ex_m2r, ex_asrc, ex_br, hz;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [XLEN-1:0] ex_d1, ex_d2, ex_imm, ex_pc;
  logic [3:0] ex_alu;
  logic [CNT_W-1:0] cnt;
  logic [5:0] ex_ctrl;
  assign ex_ctrl = {ex_rw, ex_mr, ex_mw, ex_m2r, ex_asrc, ex_br};

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_n(rst_n), .ID_valid_i(id_valid),
    .ID_Rs1_i(id_rs1), .ID_Rs2_i(id_rs2), .ID_Rd_i(id_rd),
    .ID_RS1data_i(id_d1), .ID_RS2data_i(id_d2), .ID_Imm_i(id_imm), .ID_PC_i(id_pc),
    .ID_RegWrite_i(id_ctrl[5]), .ID_MemRead_i(id_ctrl[4]), .ID_MemWrite_i(id_ctrl[3]),
    .ID_MemtoReg_i(id_ctrl[2]), .ID_ALUSrc_i(id_ctrl[1]), .ID_Branch_i(id_ctrl[0]),
    .ID_ALUOp_i(id_alu), .flush_i(flush), .stall_ext_i(stall_ext),
    .ID_EX_valid_o(ex_valid), .ID_EX_Rs1_o(ex_rs1), .ID_EX_Rs2_o(ex_rs2), .ID_EX_Rd_o(ex_rd),
    .ID_EX_RS1data_o(ex_d1), .ID_EX_RS2data_o(ex_d2), .ID_EX_Imm_o(ex_imm), .ID_EX_PC_o(ex_pc),
    .ID_EX_RegWrite_o(ex_rw), .ID_EX_MemRead_o(ex_mr), .ID_EX_MemWrite_o(ex_mw),
    .ID_EX_MemtoReg_o(ex_m2r), .ID_EX_ALUSrc_o(ex_asrc), .ID_EX_Branch_o(ex_br),
    .ID_EX_ALUOp_o(ex_alu), .hazard_stall_o(hz), .bubble_cnt_o(cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit mon_en = 0;

  task chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_v;
  bit [4:0] m_rs1, m_rs2, m_rd;
  bit [XLEN-1:0] m_d1, m_d2, m_imm, m_pc;
  bit [5:0] m_ctrl;
  bit [3:0] m_alu;
  int m_cnt;

  function automatic bit load_use(input bit iv, input bit [4:0] r1, input bit [4:0] r2);
    return DET == 1 && m_v && m_ctrl[4] && m_rd != 0 && iv && (m_rd == r1 || m_rd == r2);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_v = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_d1 = 0; m_d2 = 0;
      m_imm = 0; m_pc = 0; m_ctrl = 0; m_alu = 0; m_cnt = 0;
    end else if (!stall_ext) begin
      bit h;
      h = load_use(id_valid, id_rs1, id_rs2);
      if (flush || h) begin
        if (!flush && m_cnt < CMAX) m_cnt++;
        m_v = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_ctrl = 0; m_alu = 0;
      end else begin
        m_v = id_valid;
        m_d1 = id_d1; m_d2 = id_d2; m_imm = id_imm; m_pc = id_pc;
        m_rs1 = id_valid ? id_rs1 : 5'd0;
        m_rs2 = id_valid ? id_rs2 : 5'd0;
        m_rd  = id_valid ? id_rd  : 5'd0;
        m_ctrl = id_valid ? id_ctrl : 6'd0;
        m_alu  = id_valid ? id_alu  : 4'd0;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("valid", 32'(ex_valid), 32'(m_v));
      chk("rs1", 32'(ex_rs1), 32'(m_rs1));
      chk("rs2", 32'(ex_rs2), 32'(m_rs2));
      chk("rd", 32'(ex_rd), 32'(m_rd));
      chk("rs1data", ex_d1, m_d1);
      chk("rs2data", ex_d2, m_d2);
      chk("imm", ex_imm, m_imm);
      chk("pc", ex_pc, m_pc);
      chk("ctrl", 32'(ex_ctrl), 32'(m_ctrl));
      chk("aluop", 32'(ex_alu), 32'(m_alu));
      chk("cnt", 32'(cnt), 32'(m_cnt));
      chk("hazard_stall", 32'(hz), 32'(load_use(id_valid, id_rs1, id_rs2) && !flush));
    end
  end

  // ---------------- stimulus ----------------
  task set_id(input bit v, input bit [4:0] r1, input bit [4:0] r2, input bit [4:0] rd,
              input bit [5:0] c, input bit [3:0] alu, input bit [31:0] pc);
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rd = rd; id_ctrl = c; id_alu = alu;
    id_pc = pc; id_imm = pc ^ 32'h0000_0F0F; id_d1 = pc + 32'h100; id_d2 = pc + 32'h200;
  endtask

  task tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; flush = 0; stall_ext = 0;
    set_id(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk("reset_valid", 32'(ex_valid), 0);
    chk("reset_cnt", 32'(cnt), 0);
    rst_n = 1'b1;
    mon_en = 1;

    // invalid slot with nonzero fields: control and indices zeroed, data loaded
    set_id(0, 3, 4, 7, C_ADD, 4'h5, 32'h40);
    tick();
    chk("inv_rd", 32'(ex_rd), 0);
    chk("inv_ctrl", 32'(ex_ctrl), 0);
    chk("inv_pc", ex_pc, 32'h40);

    // load-use on Rs2: lw x5 then add x6,x1,x5
    set_id(1, 2, 0, 5, C_LW, 4'h0, 32'h100);
    tick();
    set_id(1, 1, 5, 6, C_ADD, 4'h0, 32'h104);
    #1 chk("lu_stall", 32'(hz), 32'(DET));
    tick();
    chk("lu_bub_valid", 32'(ex_valid), 32'(1 - DET));
    chk("lu_bub_rd", 32'(ex_rd), DET ? 0 : 6);
    chk("lu_bub_rw", 32'(ex_rw), 32'(1 - DET));
    chk("lu_cnt", 32'(cnt), 32'(DET));
    tick();
    chk("lu_add_rs2", 32'(ex_rs2), 5);
    chk("lu_add_valid", 32'(ex_valid), 1);
    chk("lu_add_pc", ex_pc, 32'h104);

    // lw x0 followed by a reader of x0: never a hazard
    set_id(1, 2, 0, 0, C_LW, 4'h0, 32'h200);
    tick();
    set_id(1, 0, 0, 8, C_ADD, 4'h0, 32'h204);
    #1 chk("x0_stall", 32'(hz), 0);
    tick();
    chk("x0_valid", 32'(ex_valid), 1);

    // flush together with load-use: flush wins, not counted
    set_id(1, 2, 0, 5, C_LW, 4'h0, 32'h300);
    tick();
    set_id(1, 1, 5, 6, C_ADD, 4'h0, 32'h304);
    flush = 1;
    #1 chk("fl_stall", 32'(hz), 0);
    tick();
    chk("fl_valid", 32'(ex_valid), 0);
    chk("fl_cnt", 32'(cnt), 32'(DET));
    chk("fl_pc_held", ex_pc, 32'h300);
    flush = 0;

    // freeze 3 cycles with flush and new inputs, then flush bubble
    set_id(1, 9, 10, 11, C_SW, 4'h3, 32'h400);
    tick();
    stall_ext = 1; flush = 1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, 12 + i[4:0], 13, 14, C_ADD, 4'h7, 32'h500 + 32'(i));
      tick();
      chk("frz_pc", ex_pc, 32'h400);
      chk("frz_rd", 32'(ex_rd), 11);
      chk("frz_valid", 32'(ex_valid), 1);
    end
    stall_ext = 0;
    tick();
    chk("frz_flush_valid", 32'(ex_valid), 0);
    chk("frz_flush_pc", ex_pc, 32'h400);
    flush = 0;

    // freeze while load-use is pending: stall still reported, nothing counted
    set_id(1, 0, 0, 7, C_LW, 4'h0, 32'h600);
    tick();
    set_id(1, 7, 3, 9, C_ADD, 4'h1, 32'h604);
    stall_ext = 1;
    #1 chk("frzh_stall", 32'(hz), 32'(DET));
    tick();
    chk("frzh_cnt", 32'(cnt), 32'(DET));
    chk("frzh_rd", 32'(ex_rd), 7);
    stall_ext = 0;
    tick(); tick();

    // asynchronous reset between edges
    set_id(1, 4, 5, 6, C_LW, 4'h9, 32'h700);
    tick();
    rst_n = 0;
    #1;
    chk("ar_valid", 32'(ex_valid), 0);
    chk("ar_pc", ex_pc, 0);
    chk("ar_rd", 32'(ex_rd), 0);
    chk("ar_ctrl", 32'(ex_ctrl), 0);
    chk("ar_cnt", 32'(cnt), 0);
    chk("ar_stall", 32'(hz), 0);
    #1 rst_n = 1;
    tick();

    // saturation: 14 hazards bring the counter to CMAX-1, then 3 more
    for (int i = 0; i < CMAX + 2; i++) begin
      set_id(1, 1, 2, 9, C_LW, 4'h0, 32'h800 + 32'(i * 8));
      tick();
      set_id(1, 9, 3, 10, C_ADD, 4'h0, 32'h804 + 32'(i * 8));
      tick();
      if (i == CMAX - 2) chk("sat_pre", 32'(cnt), DET ? CMAX - 1 : 0);
      if (i >= CMAX - 1) chk("sat_hold", 32'(cnt), DET ? CMAX : 0);
    end
    set_id(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();

    mon_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register between decode (ID) and execute (EX) of the 5-stage RISC-V core, with integrated load-use hazard detection. It captures decoded operands, immediate, PC, register indices and control bits each cycle, and presents them to the EX datapath and to the forwarding unit as the ID_EX_* signals. It inserts a one-cycle bubble on a load-use dependency, and drives a bubble on branch flush. A saturating counter records the hazard bubbles it inserts.

## Interface

- XLEN, 32, data/PC width
- CNT_W, 16, bubble counter width

- clk_i  in  1  core clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ID_valid_i  in  1  decode slot holds a real instruction
- ID_Rs1_i, ID_Rs2_i, ID_Rd_i  in  5  decoded register indices
- ID_RS1data_i, ID_RS2data_i  in  XLEN  register-file read data
- ID_Imm_i, ID_PC_i  in  XLEN  immediate, instruction PC
- ID_RegWrite_i, ID_MemRead_i, ID_MemWrite_i, ID_MemtoReg_i, ID_ALUSrc_i, ID_Branch_i  in  1  control bits
- ID_ALUOp_i  in  4  ALU operation
- flush_i  in  1  branch/jump resolved taken in EX; kill the decode slot
- stall_ext_i  in  1  global freeze (memory wait)
- ID_EX_valid_o  out  1
- ID_EX_Rs1_o, ID_EX_Rs2_o, ID_EX_Rd_o  out  5  (Rs1/Rs2 feed the forwarding unit)
- ID_EX_RS1data_o, ID_EX_RS2data_o, ID_EX_Imm_o, ID_EX_PC_o  out  XLEN
- ID_EX_RegWrite_o, ID_EX_MemRead_o, ID_EX_MemWrite_o, ID_EX_MemtoReg_o, ID_EX_ALUSrc_o, ID_EX_Branch_o  out  1
- ID_EX_ALUOp_o  out  4
- hazard_stall_o  out  1  combinational; freeze PC and IF/ID this cycle
- bubble_cnt_o  out  CNT_W  hazard bubbles inserted, saturating

## Operation

- Hazard condition H is asserted when all of the following hold:
  - ID_EX_valid_o and ID_EX_MemRead_o
  - ID_EX_Rd_o != 0
  - ID_valid_i
  - ID_EX_Rd_o == ID_Rs1_i or ID_EX_Rd_o == ID_Rs2_i
- hazard_stall_o = H & ~flush_i. A flushed decode slot never stalls.
- On each rising edge, apply the first matching rule:
  1. stall_ext_i=1: every register holds, counter holds. flush_i is ignored; upstream keeps flush_i asserted until the freeze ends.
  2. flush_i=1: load a bubble.
  3. H=1: load a bubble and increment bubble_cnt_o.
  4. Otherwise: load all ID_* inputs. ID_EX_valid_o <= ID_valid_i. If ID_valid_i=0, control bits and register indices are forced to 0.
- Bubble contents:
  - valid, all control bits, ALUOp, Rs1, Rs2 and Rd forced to 0, so the forwarding unit cannot match a bubble.
  - RS1data, RS2data, Imm and PC hold their previous values.
- bubble_cnt_o increments by 1 per hazard bubble and stops at 2^CNT_W-1. Flush bubbles are not counted.
- No state machine beyond the register. The only multi-cycle behaviour is one bubble per load-use; after that bubble the load leaves EX, so H clears.

## Timing

- Latency is 1 cycle: inputs sampled on edge n appear on outputs after edge n.
- Reset (rst_n=0) is asynchronous, immediate and independent of the clock. All outputs go to 0: valid, control bits, indices, data, PC, Imm, bubble_cnt_o. hazard_stall_o then evaluates to 0.
- Reset may assert mid-operation, including during a stall or a bubble. The first edge after deassertion follows normal rule priority.
- Load-use sequence:
  - Cycle n: load in EX, dependent instruction in ID, hazard_stall_o=1.
  - Cycle n+1: bubble in EX, dependent instruction still in ID, load in MEM.
  - Cycle n+2: dependent instruction in EX, load in WB. The forwarding unit selects MEM/WB (01).
- Simultaneous events:
  - flush_i with H: flush wins, no count, hazard_stall_o=0.
  - stall_ext_i with H: hold. hazard_stall_o still reflects H, so upstream also holds.
- hazard_stall_o is purely combinational from current register state and ID_* inputs. It has no edge dependency.

## Configuration

- LOAD_USE_DETECT_EN
  - Defined: hazard detection, hazard bubbles and bubble_cnt_o behave as above.
  - Undefined: H is constant 0, hazard_stall_o is tied 0, and bubble_cnt_o is tied 0 with no counter flops. Flush, freeze and reset behaviour are unchanged. The toolchain is then responsible for scheduling load-use dependencies.

## Test plan

- Reset mid-stream: pulse rst_n low between clock edges while ID_EX_* holds nonzero values. All outputs read 0 before the next edge, and bubble_cnt_o=0.
- Load-use on Rs2:
  - Stimulus: lw x5 in EX (MemRead=1, Rd=5) and add x6,x1,x5 in ID.
  - Required: hazard_stall_o=1. Next cycle ID_EX_valid_o=0, ID_EX_Rd_o=0, RegWrite=0, bubble_cnt_o=1. The following cycle the add is registered with Rs2=5.
- Rd=x0 load: lw x0 in EX and a reader of x0 in ID. hazard_stall_o=0 and no bubble.
- Flush with hazard: same setup as the Rs2 load-use case, plus flush_i=1. hazard_stall_o=0, a bubble is loaded, and bubble_cnt_o is unchanged.
- Freeze: stall_ext_i=1 for 3 cycles with flush_i=1 and new ID_* inputs. Outputs hold unchanged for all 3 cycles. On the first edge after stall_ext_i falls (flush_i still 1), a bubble is loaded.
- Saturation: preload the counter to 0xFFFE and force 3 hazards. bubble_cnt_o reads 0xFFFF and stays there.
